io_arbiter: RTL and testbench
=============================

# io_arbiter

Two-master arbiter that lets two requesters share the single I/O device port of the system. The requesters are the core and a second master such as a DMA engine or a second core. It sits between the masters and `io_devices`. It arbitrates the read (in) channel and the write (out) channel independently, each with round-robin fairness. Each channel runs the same level-request / pulse-ack handshake the core uses, on both sides.

## Interface
Parameters:
- D_WIDTH, 34, data word width
- PA_WIDTH, 4, port address width

Ports (x = 0 or 1, one set per master). Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock; all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- mx_in_req_i  in  1  master x read request, level, held until mx_in_ack_o
- mx_in_addr_i  in  PA_WIDTH  master x read address
- mx_in_data_o  out  D_WIDTH  read data to master x, valid while mx_in_ack_o=1
- mx_in_ack_o  out  1  one-cycle read-completion pulse to master x
- mx_out_req_i  in  1  master x write request, level, held until mx_out_ack_o
- mx_out_addr_i  in  PA_WIDTH  master x write address
- mx_out_data_i  in  D_WIDTH  master x write data
- mx_out_ack_o  out  1  one-cycle write-completion pulse to master x
- in_req_o  out  1  read request to device
- in_addr_o  out  PA_WIDTH  read address to device
- in_data_i  in  D_WIDTH  read data from device, valid with in_ack_i
- in_ack_i  in  1  device read ack
- out_req_o  out  1  write request to device
- out_addr_o  out  PA_WIDTH  write address to device
- out_data_o  out  D_WIDTH  write data to device
- out_ack_i  in  1  device write ack

## Operation
- The read and write channels are identical, independent FSMs and may be busy at the same time. The description below is per channel.
- FSM states are IDLE, BUSY and RESP.
- **IDLE**
  - When no request is present, stay in IDLE.
  - When exactly one master requests, grant it.
  - When both request, grant the master named by the priority pointer `prio` (reset value 0).
  - On grant: register the granted id, the address and (write channel) the data; assert the device req; go to BUSY.
- **BUSY**
  - Device req, address and data are held stable from the registered copies. Master input changes are ignored.
  - When device ack=1: drop the device req, assert the granted master's ack, capture in_data_i into the read-data register (read channel only), set `prio` to the other master, and go to RESP.
- **RESP**
  - The master ack is high for exactly this cycle.
  - The next state is always IDLE. RESP is a dead cycle so that the granted master's stale req is never re-sampled.
- mx_in_data_o:
  - Both masters' mx_in_data_o are driven from the read-data register.
  - The register holds its last value between transactions.
  - It is valid only while the corresponding ack is high.
- A request that arrives while the channel is BUSY or in RESP waits; nothing is queued beyond the held level request.
- A device ack seen in IDLE or RESP is ignored.
- **Reset (async):**
  - All FSMs go to IDLE and `prio` goes to 0.
  - All req, ack, address and data outputs go to 0.
  - An in-flight transaction is abandoned with no ack to the master.

## Timing
- A master req is sampled at edge N. Device req is high from cycle N+1 (registered; no combinational path from master inputs to device outputs).
- Device ack is high in cycle A. The master ack and read data are high/valid in cycle A+1, and device req is low in A+1.
- The channel is back in IDLE at A+2 and can grant at edge A+2, so the device req can be high again at A+3.
- Minimum period per transaction, with a device that acks in the first BUSY cycle: 3 cycles.
- Master contract:
  - Hold req, addr and data until the ack pulse.
  - Deassert req no later than the cycle after the ack.

## Test plan
- **Reset:**
  - Stimulus: assert reset_i mid-cycle with random inputs.
  - Required response: every output is 0 immediately (asynchronous), and stays 0 until a request arrives after reset is released.
- **Single read:**
  - Stimulus: m0 reads addr 4'h3; the device acks 2 cycles after in_req_o with in_data_i = 34'h2_DEAD_BEEF.
  - Required response: in_addr_o = 4'h3 one cycle after the req; m0_in_ack_o is a single pulse with m0_in_data_o = 34'h2_DEAD_BEEF; m1_in_ack_o stays 0.
- **Contention:**
  - Stimulus: right after reset, m0 and m1 both hold read requests (addr 4'h1 and 4'h2), and m0 re-requests immediately after its ack.
  - Required response: service order is m0, m1, m0. This shows the round-robin pointer toggling.
- **Concurrent channels:**
  - Stimulus: m0 reads 4'h5 while m1 writes 34'h1_2345_6789 to 4'hA in the same cycle.
  - Required response: in_req_o and out_req_o both rise at N+1, out_data_o = 34'h1_2345_6789, and each master receives exactly one ack.
- **Reset mid-transaction:**
  - Stimulus: pulse reset_i while the write channel is BUSY for m1, then release it with m1 still requesting.
  - Required response: no ack is issued before the reset; out_req_o is reissued after the reset with m1's address and data; `prio` is 0, so m0 wins a tie on the next contended cycle.
- **Stale ack:**
  - Stimulus: pulse in_ack_i while the read channel is IDLE.
  - Required response: no master ack and no state change.

Source files
------------

// File: rtl/io_arbiter_if.sv
// Bundle of the two master ports and the device port of io_arbiter.
// The arbiter uses the slave view; the system or bench uses the master view.
interface io_arbiter_if #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4
);
  logic                m0_in_req_i;
  logic [PA_WIDTH-1:0] m0_in_addr_i;
  logic [D_WIDTH-1:0]  m0_in_data_o;
  logic                m0_in_ack_o;
  logic                m0_out_req_i;
  logic [PA_WIDTH-1:0] m0_out_addr_i;
  logic [D_WIDTH-1:0]  m0_out_data_i;
  logic                m0_out_ack_o;

  logic                m1_in_req_i;
  logic [PA_WIDTH-1:0] m1_in_addr_i;
  logic [D_WIDTH-1:0]  m1_in_data_o;
  logic                m1_in_ack_o;
  logic                m1_out_req_i;
  logic [PA_WIDTH-1:0] m1_out_addr_i;
  logic [D_WIDTH-1:0]  m1_out_data_i;
  logic                m1_out_ack_o;

  logic                in_req_o;
  logic [PA_WIDTH-1:0] in_addr_o;
  logic [D_WIDTH-1:0]  in_data_i;
  logic                in_ack_i;
  logic                out_req_o;
  logic [PA_WIDTH-1:0] out_addr_o;
  logic [D_WIDTH-1:0]  out_data_o;
  logic                out_ack_i;

  modport slave (
    input  m0_in_req_i, m0_in_addr_i, m0_out_req_i, m0_out_addr_i, m0_out_data_i,
    input  m1_in_req_i, m1_in_addr_i, m1_out_req_i, m1_out_addr_i, m1_out_data_i,
    output m0_in_data_o, m0_in_ack_o, m0_out_ack_o,
    output m1_in_data_o, m1_in_ack_o, m1_out_ack_o,
    input  in_data_i, in_ack_i, out_ack_i,
    output in_req_o, in_addr_o, out_req_o, out_addr_o, out_data_o
  );

  modport master (
    output m0_in_req_i, m0_in_addr_i, m0_out_req_i, m0_out_addr_i, m0_out_data_i,
    output m1_in_req_i, m1_in_addr_i, m1_out_req_i, m1_out_addr_i, m1_out_data_i,
    input  m0_in_data_o, m0_in_ack_o, m0_out_ack_o,
    input  m1_in_data_o, m1_in_ack_o, m1_out_ack_o,
    output in_data_i, in_ack_i, out_ack_i,
    input  in_req_o, in_addr_o, out_req_o, out_addr_o, out_data_o
  );
endinterface

// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter in front of the I/O device port.
// Read and write channels are independent IDLE/BUSY/RESP state machines.
module io_arbiter #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4
) (
  input logic         clk,
  input logic         reset_i,
  io_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          in_state;
  logic                in_prio;
  logic                in_gnt;
  logic                in_req_q;
  logic [PA_WIDTH-1:0] in_addr_q;
  logic [D_WIDTH-1:0]  in_data_q;
  logic                in_ack0_q;
  logic                in_ack1_q;
  logic                in_pick;

  logic [1:0]          out_state;
  logic                out_prio;
  logic                out_gnt;
  logic                out_req_q;
  logic [PA_WIDTH-1:0] out_addr_q;
  logic [D_WIDTH-1:0]  out_data_q;
  logic                out_ack0_q;
  logic                out_ack1_q;
  logic                out_pick;

  // A lone requester wins outright; on a tie the priority pointer decides.
  assign in_pick  = (bus.m0_in_req_i && bus.m1_in_req_i) ? in_prio : bus.m1_in_req_i;
  assign out_pick = (bus.m0_out_req_i && bus.m1_out_req_i) ? out_prio : bus.m1_out_req_i;

  // Read channel
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      in_state  <= IDLE;
      in_prio   <= 1'b0;
      in_gnt    <= 1'b0;
      in_req_q  <= 1'b0;
      in_addr_q <= '0;
      in_data_q <= '0;
      in_ack0_q <= 1'b0;
      in_ack1_q <= 1'b0;
    end else begin
      case (in_state)
        IDLE: begin
          if (bus.m0_in_req_i || bus.m1_in_req_i) begin
            in_gnt    <= in_pick;
            in_addr_q <= in_pick ? bus.m1_in_addr_i : bus.m0_in_addr_i;
            in_req_q  <= 1'b1;
            in_state  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.in_ack_i) begin
            in_req_q  <= 1'b0;
            in_ack0_q <= ~in_gnt;
            in_ack1_q <= in_gnt;
            in_data_q <= bus.in_data_i;
            in_prio   <= ~in_gnt;
            in_state  <= RESP;
          end
        end
        RESP: begin
          in_ack0_q <= 1'b0;
          in_ack1_q <= 1'b0;
          in_state  <= IDLE;
        end
        default: in_state <= IDLE;
      endcase
    end
  end

  // Write channel
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      out_state  <= IDLE;
      out_prio   <= 1'b0;
      out_gnt    <= 1'b0;
      out_req_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_ack0_q <= 1'b0;
      out_ack1_q <= 1'b0;
    end else begin
      case (out_state)
        IDLE: begin
          if (bus.m0_out_req_i || bus.m1_out_req_i) begin
            out_gnt    <= out_pick;
            out_addr_q <= out_pick ? bus.m1_out_addr_i : bus.m0_out_addr_i;
            out_data_q <= out_pick ? bus.m1_out_data_i : bus.m0_out_data_i;
            out_req_q  <= 1'b1;
            out_state  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.out_ack_i) begin
            out_req_q  <= 1'b0;
            out_ack0_q <= ~out_gnt;
            out_ack1_q <= out_gnt;
            out_prio   <= ~out_gnt;
            out_state  <= RESP;
          end
        end
        RESP: begin
          out_ack0_q <= 1'b0;
          out_ack1_q <= 1'b0;
          out_state  <= IDLE;
        end
        default: out_state <= IDLE;
      endcase
    end
  end

  assign bus.in_req_o     = in_req_q;
  assign bus.in_addr_o    = in_addr_q;
  assign bus.m0_in_data_o = in_data_q;
  assign bus.m1_in_data_o = in_data_q;
  assign bus.m0_in_ack_o  = in_ack0_q;
  assign bus.m1_in_ack_o  = in_ack1_q;

  assign bus.out_req_o    = out_req_q;
  assign bus.out_addr_o   = out_addr_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.m0_out_ack_o = out_ack0_q;
  assign bus.m1_out_ack_o = out_ack1_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: stimulus pushes expected master acks into
// per-channel queues, and a negedge monitor pops them as acks appear.
module tb_io_arbiter;

  typedef struct packed {
    logic        id;
    logic [33:0] data;
  } rsp_t;

  logic clk;
  logic reset_i;
  logic mon_en;
  int   checks;
  int   errors;
  logic [33:0] last_rd;
  rsp_t rd_q[$];
  rsp_t wr_q[$];

  io_arbiter_if #(.D_WIDTH(34), .PA_WIDTH(4)) bus ();

  io_arbiter #(.D_WIDTH(34), .PA_WIDTH(4)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({bus.in_req_o, bus.in_addr_o, bus.out_req_o, bus.out_addr_o, bus.out_data_o,
                 bus.m0_in_ack_o, bus.m1_in_ack_o, bus.m0_out_ack_o, bus.m1_out_ack_o,
                 bus.m0_in_data_o, bus.m1_in_data_o});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.m0_in_req_i   = 1'b0; bus.m0_in_addr_i  = '0;
    bus.m0_out_req_i  = 1'b0; bus.m0_out_addr_i = '0; bus.m0_out_data_i = '0;
    bus.m1_in_req_i   = 1'b0; bus.m1_in_addr_i  = '0;
    bus.m1_out_req_i  = 1'b0; bus.m1_out_addr_i = '0; bus.m1_out_data_i = '0;
    bus.in_data_i     = '0;   bus.in_ack_i      = 1'b0;
    bus.out_ack_i     = 1'b0;
  endtask

  task automatic apply_stimulus_random();
    logic [63:0] r0;
    logic [63:0] r1;
    logic [63:0] r2;
    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    bus.m0_in_req_i   = 1'($urandom_range(0, 1));
    bus.m1_in_req_i   = 1'($urandom_range(0, 1));
    bus.m0_out_req_i  = 1'($urandom_range(0, 1));
    bus.m1_out_req_i  = 1'($urandom_range(0, 1));
    bus.in_ack_i      = 1'($urandom_range(0, 1));
    bus.out_ack_i     = 1'($urandom_range(0, 1));
    bus.m0_in_addr_i  = 4'($urandom);
    bus.m1_in_addr_i  = 4'($urandom);
    bus.m0_out_addr_i = 4'($urandom);
    bus.m1_out_addr_i = 4'($urandom);
    bus.m0_out_data_i = r0[33:0];
    bus.m1_out_data_i = r1[33:0];
    bus.in_data_i     = r2[33:0];
  endtask

  task automatic do_reset();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  // Device side of one read: wait for in_req_o, ack after 'delay' cycles.
  // Returns at the negedge of the cycle in which the master ack is high.
  task automatic rd_txn(input logic id, input logic [3:0] exp_addr, input logic [33:0] data, input int delay);
    int lat;
    rsp_t e;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.in_req_o) begin
        lat = i;
        break;
      end
    end
    check_output("rd_req_latency", 128'(lat), 128'(1));
    check_output("rd_addr", 128'(bus.in_addr_o), 128'(exp_addr));
    if (lat < 0) return;
    repeat (delay) @(posedge clk);
    #1;
    check_output("rd_addr_hold", 128'(bus.in_addr_o), 128'(exp_addr));
    e.id = id;
    e.data = data;
    rd_q.push_back(e);
    last_rd = data;
    bus.in_ack_i  = 1'b1;
    bus.in_data_i = data;
    tick();
    bus.in_ack_i  = 1'b0;
    bus.in_data_i = '0;
    @(negedge clk);
    check_output("rd_req_drop", 128'(bus.in_req_o), 128'(0));
  endtask

  task automatic wr_txn(input logic id, input logic [3:0] exp_addr, input logic [33:0] exp_data, input int delay);
    int lat;
    rsp_t e;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_req_o) begin
        lat = i;
        break;
      end
    end
    check_output("wr_req_latency", 128'(lat), 128'(1));
    check_output("wr_addr", 128'(bus.out_addr_o), 128'(exp_addr));
    check_output("wr_data", 128'(bus.out_data_o), 128'(exp_data));
    if (lat < 0) return;
    repeat (delay) @(posedge clk);
    #1;
    e.id = id;
    e.data = '0;
    wr_q.push_back(e);
    bus.out_ack_i = 1'b1;
    tick();
    bus.out_ack_i = 1'b0;
    @(negedge clk);
    check_output("wr_req_drop", 128'(bus.out_req_o), 128'(0));
  endtask

  // Scoreboard monitor: every master ack must match the head of its queue.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (mon_en && !reset_i) begin
      if (bus.m0_in_ack_o || bus.m1_in_ack_o) begin
        if (rd_q.size() == 0) begin
          check_output("rd_ack_unexpected", 128'({bus.m1_in_ack_o, bus.m0_in_ack_o}), 128'(0));
        end else begin
          e = rd_q.pop_front();
          check_output("rd_ack_who", 128'({bus.m1_in_ack_o, bus.m0_in_ack_o}), e.id ? 128'(2) : 128'(1));
          check_output("rd_ack_data", 128'(e.id ? bus.m1_in_data_o : bus.m0_in_data_o), 128'(e.data));
        end
      end
      if (bus.m0_out_ack_o || bus.m1_out_ack_o) begin
        if (wr_q.size() == 0) begin
          check_output("wr_ack_unexpected", 128'({bus.m1_out_ack_o, bus.m0_out_ack_o}), 128'(0));
        end else begin
          e = wr_q.pop_front();
          check_output("wr_ack_who", 128'({bus.m1_out_ack_o, bus.m0_out_ack_o}), e.id ? 128'(2) : 128'(1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    mon_en  = 1'b0;
    last_rd = '0;
    reset_i = 1'b1;
    zero_inputs();
    tick();
    tick();
    reset_i = 1'b0;

    // Reset asserted mid-cycle while random traffic is in flight
    for (int i = 0; i < 6; i++) begin
      tick();
      apply_stimulus_random();
    end
    #2;
    reset_i = 1'b1;
    #1;
    check_output("reset_async_outputs", all_outputs(), 128'(0));
    zero_inputs();
    tick();
    tick();
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("post_reset_idle", all_outputs(), 128'(0));
    end
    mon_en = 1'b1;

    // Single read by m0; the address input changes during BUSY and is ignored
    tick();
    bus.m0_in_req_i  = 1'b1;
    bus.m0_in_addr_i = 4'h3;
    fork
      rd_txn(1'b0, 4'h3, 34'h2_DEAD_BEEF, 2);
      begin
        repeat (2) @(negedge clk);
        bus.m0_in_addr_i = 4'hF;
      end
    join
    bus.m0_in_req_i = 1'b0;

    // Contention right after reset: m0, m1, m0
    do_reset();
    tick();
    bus.m0_in_req_i  = 1'b1; bus.m0_in_addr_i = 4'h1;
    bus.m1_in_req_i  = 1'b1; bus.m1_in_addr_i = 4'h2;
    rd_txn(1'b0, 4'h1, 34'h0_1111_1111, 1);
    rd_txn(1'b1, 4'h2, 34'h1_2222_2222, 1);
    bus.m1_in_req_i = 1'b0;
    rd_txn(1'b0, 4'h1, 34'h3_3333_3333, 1);
    bus.m0_in_req_i = 1'b0;

    // Concurrent read and write channels
    tick();
    bus.m0_in_req_i   = 1'b1; bus.m0_in_addr_i  = 4'h5;
    bus.m1_out_req_i  = 1'b1; bus.m1_out_addr_i = 4'hA; bus.m1_out_data_i = 34'h1_2345_6789;
    fork
      begin
        rd_txn(1'b0, 4'h5, 34'h0_5555_AAAA, 1);
        bus.m0_in_req_i = 1'b0;
      end
      begin
        wr_txn(1'b1, 4'hA, 34'h1_2345_6789, 2);
        bus.m1_out_req_i = 1'b0;
      end
    join

    // Reset while the write channel is BUSY for m1
    tick();
    bus.m1_out_req_i  = 1'b1; bus.m1_out_addr_i = 4'hC; bus.m1_out_data_i = 34'h3_0F0F_0F0F;
    @(negedge clk);
    @(negedge clk);
    check_output("wr_busy_before_reset", 128'(bus.out_req_o), 128'(1));
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    check_output("reset_mid_outputs", all_outputs(), 128'(0));
    tick();
    reset_i = 1'b0;
    wr_txn(1'b1, 4'hC, 34'h3_0F0F_0F0F, 1);
    bus.m1_out_req_i = 1'b0;

    // Read tie after reset: pointer restarted at 0, so m0 goes first
    tick();
    bus.m0_in_req_i = 1'b1; bus.m0_in_addr_i = 4'h6;
    bus.m1_in_req_i = 1'b1; bus.m1_in_addr_i = 4'h7;
    rd_txn(1'b0, 4'h6, 34'h2_6666_6666, 1);
    bus.m0_in_req_i = 1'b0;
    rd_txn(1'b1, 4'h7, 34'h1_7777_7777, 1);
    bus.m1_in_req_i = 1'b0;

    // Stale device ack while the read channel is IDLE
    tick();
    bus.in_ack_i  = 1'b1;
    bus.in_data_i = 34'h0_BAD0_BAD0;
    tick();
    bus.in_ack_i  = 1'b0;
    bus.in_data_i = '0;
    repeat (3) begin
      @(negedge clk);
      check_output("stale_no_req", 128'(bus.in_req_o), 128'(0));
      check_output("stale_data_hold", 128'(bus.m0_in_data_o), 128'(last_rd));
    end
    tick();
    bus.m1_in_req_i = 1'b1; bus.m1_in_addr_i = 4'h9;
    rd_txn(1'b1, 4'h9, 34'h2_9999_0000, 1);
    bus.m1_in_req_i = 1'b0;

    repeat (4) @(negedge clk);
    check_output("rd_queue_drained", 128'(rd_q.size()), 128'(0));
    check_output("wr_queue_drained", 128'(wr_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
